// File: rtl/pipeline_ctrl.sv
// Purpose: sequencing controller for the LC-3b five-stage pipeline; drives latch
//          load/bubble strobes, holds memory handshakes, resolves load-use and branch.
// Latency: all strobes combinational from state/flags/inputs; state, flags, counters
//          update on the rising clk edge.
// Backpressure: whole pipe stalls until both the instruction and data memories have
//          responded; an early response is remembered in a sticky flag.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_resp / imem_read           instruction memory done pulse / fetch request
//   dmem_req, dmem_resp/dmem_enable data access requested, done pulse / MEM strobe gate
//   idex_mem_read, idex_dest        load in EX and its destination register
//   ifid_sr1/2, ifid_sr1/2_used     source registers decoded in ID and their use bits
//   branch_taken                    MEM-stage redirect
//   load_*, flush_*                 latch load enables and bubble inserts
//   stall_count, flush_count        saturating event counters
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_resp,
    output logic        imem_read,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    output logic        dmem_enable,
    input  logic        idex_mem_read,
    input  logic [2:0]  idex_dest,
    input  logic [2:0]  ifid_sr1,
    input  logic [2:0]  ifid_sr2,
    input  logic        ifid_sr1_used,
    input  logic        ifid_sr2_used,
    input  logic        branch_taken,
    output logic        load_pc,
    output logic        load_ifid,
    output logic        load_idex,
    output logic        load_exmem,
    output logic        load_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic {INIT, RUN} state_t;

    state_t      state_q, state_d;
    logic        imem_done_q, imem_done_d;
    logic        dmem_done_q, dmem_done_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic i_ok, d_ok, advance, hazard;

    // A response is accepted either live this cycle or from its sticky flag.
    assign i_ok    = imem_done_q | imem_resp;
    assign d_ok    = ~dmem_req | dmem_done_q | dmem_resp;
    assign advance = i_ok & d_ok;
    assign hazard  = idex_mem_read &
                     ((ifid_sr1_used & (ifid_sr1 == idex_dest)) |
                      (ifid_sr2_used & (ifid_sr2 == idex_dest)));

    always_comb begin
        state_d       = state_q;
        imem_done_d   = imem_done_q;
        dmem_done_d   = dmem_done_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        imem_read     = 1'b0;
        dmem_enable   = 1'b0;
        load_pc       = 1'b0;
        load_ifid     = 1'b0;
        load_idex     = 1'b0;
        load_exmem    = 1'b0;
        load_memwb    = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        flush_exmem   = 1'b0;
        // Counters read as zero while reset is held, even before the first edge.
        stall_count   = reset ? 16'h0000 : stall_count_q;
        flush_count   = reset ? 16'h0000 : flush_count_q;

        if (!reset) begin
            case (state_q)
                INIT: begin
                    // Fill the three control latches with bubbles; PC stays put.
                    load_ifid   = 1'b1;
                    load_idex   = 1'b1;
                    load_exmem  = 1'b1;
                    load_memwb  = 1'b1;
                    flush_ifid  = 1'b1;
                    flush_idex  = 1'b1;
                    flush_exmem = 1'b1;
                    state_d     = RUN;
                end
                RUN: begin
                    imem_read   = ~imem_done_q;
                    dmem_enable = dmem_req & ~dmem_done_q;
                    if (advance) begin
                        imem_done_d = 1'b0;
                        dmem_done_d = 1'b0;
                        load_idex   = 1'b1;
                        load_exmem  = 1'b1;
                        load_memwb  = 1'b1;
                        if (branch_taken) begin
                            // Squash the three younger instructions.
                            load_pc     = 1'b1;
                            load_ifid   = 1'b1;
                            flush_ifid  = 1'b1;
                            flush_idex  = 1'b1;
                            flush_exmem = 1'b1;
                            if (flush_count_q != 16'hFFFF)
                                flush_count_d = flush_count_q + 16'd1;
                        end else if (hazard) begin
                            // Hold PC and ID for one cycle, bubble into EX.
                            flush_idex = 1'b1;
                        end else begin
                            load_pc   = 1'b1;
                            load_ifid = 1'b1;
                        end
                    end else begin
                        if (imem_resp)
                            imem_done_d = 1'b1;
                        // A data response with no request pending is stray; drop it.
                        if (dmem_resp & dmem_req)
                            dmem_done_d = 1'b1;
                        if (stall_count_q != 16'hFFFF)
                            stall_count_d = stall_count_q + 16'd1;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            imem_done_q   <= 1'b0;
            dmem_done_q   <= 1'b0;
            stall_count_q <= 16'h0000;
            flush_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            imem_done_q   <= imem_done_d;
            dmem_done_q   <= dmem_done_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose: self-checking bench for pipeline_ctrl.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: memory responses are scripted per cycle from stimulus tables.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_resp, imem_read;
    logic        dmem_req, dmem_resp, dmem_enable;
    logic        idex_mem_read;
    logic [2:0]  idex_dest, ifid_sr1, ifid_sr2;
    logic        ifid_sr1_used, ifid_sr2_used;
    logic        branch_taken;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        flush_ifid, flush_idex, flush_exmem;
    logic [15:0] stall_count, flush_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Observed strobes: {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
    //                    flush_ifid, flush_idex, flush_exmem, imem_read, dmem_enable}
    logic [9:0] obs;
    assign obs = {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                  flush_ifid, flush_idex, flush_exmem, imem_read, dmem_enable};

    logic [9:0] sb_q[$];

    typedef struct packed {
        logic       rst;
        logic       ir;
        logic       dq;
        logic       dr;
        logic       br;
        logic       mr;
        logic [2:0] dest;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       u1;
        logic       u2;
    } stim_t;

    pipeline_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .imem_resp     (imem_resp),
        .imem_read     (imem_read),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .dmem_enable   (dmem_enable),
        .idex_mem_read (idex_mem_read),
        .idex_dest     (idex_dest),
        .ifid_sr1      (ifid_sr1),
        .ifid_sr2      (ifid_sr2),
        .ifid_sr1_used (ifid_sr1_used),
        .ifid_sr2_used (ifid_sr2_used),
        .branch_taken  (branch_taken),
        .load_pc       (load_pc),
        .load_ifid     (load_ifid),
        .load_idex     (load_idex),
        .load_exmem    (load_exmem),
        .load_memwb    (load_memwb),
        .flush_ifid    (flush_ifid),
        .flush_idex    (flush_idex),
        .flush_exmem   (flush_exmem),
        .stall_count   (stall_count),
        .flush_count   (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic stim_t mk_s(input logic rst, ir, dq, dr, br, mr,
                                   input logic [2:0] dest, sr1, sr2,
                                   input logic u1, u2);
        stim_t s;
        s = '{rst, ir, dq, dr, br, mr, dest, sr1, sr2, u1, u2};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        reset         = s.rst;
        imem_resp     = s.ir;
        dmem_req      = s.dq;
        dmem_resp     = s.dr;
        branch_taken  = s.br;
        idex_mem_read = s.mr;
        idex_dest     = s.dest;
        ifid_sr1      = s.sr1;
        ifid_sr2      = s.sr2;
        ifid_sr1_used = s.u1;
        ifid_sr2_used = s.u2;
    endtask

    // Leaves the bench 1 unit into the first RUN cycle with idle inputs.
    task automatic do_reset();
        drive(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stim_t st[4];
        logic [9:0] ex[4];
        logic [9:0] e;
        st[0] = mk_s(1, 1, 1, 1, 1, 1, 3, 3, 3, 1, 1); ex[0] = 10'b00000_000_0_0;
        st[1] = mk_s(1, 1, 1, 1, 1, 1, 3, 3, 3, 1, 1); ex[1] = 10'b00000_000_0_0;
        st[2] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = 10'b01111_111_0_0;
        st[3] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[3] = 10'b00000_000_1_0;
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb_q.push_back(ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_seq[%0d]: got %b want %b", i, obs, e);
            end
            n_chk++;
            if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_counters[%0d]: got stall=%0d flush=%0d want 0/0", i, stall_count, flush_count);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imem_wait();
        stim_t st[3];
        logic [9:0] ex[3];
        logic [9:0] e;
        do_reset();
        st[0] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[0] = 10'b00000_000_1_0;
        st[1] = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[1] = 10'b00000_000_1_0;
        st[2] = mk_s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = 10'b11111_000_1_0;
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb_q.push_back(ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL imem_wait[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (stall_count !== 16'd2) begin
            n_fail++;
            $display("FAIL imem_wait_stall_count: got %0d want 2", stall_count);
        end
    endtask

    task automatic test_dmem_first();
        stim_t st[6];
        logic [9:0] ex[6];
        logic [9:0] e;
        do_reset();
        st[0] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[0] = 10'b00000_000_1_1;
        st[1] = mk_s(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); ex[1] = 10'b00000_000_1_1;
        st[2] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = 10'b00000_000_1_0;
        st[3] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[3] = 10'b00000_000_1_0;
        st[4] = mk_s(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[4] = 10'b11111_000_1_0;
        // Flags cleared by the advance: the next access waits again.
        st[5] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[5] = 10'b00000_000_1_1;
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            sb_q.push_back(ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL dmem_first[%0d]: got %b want %b", i, obs, e);
            end
            if (i == 4) begin
                n_chk++;
                if (stall_count !== 16'd4) begin
                    n_fail++;
                    $display("FAIL dmem_first_stall_count: got %0d want 4", stall_count);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t st[5];
        logic [9:0] ex[5];
        logic [9:0] e;
        do_reset();
        st[0] = mk_s(0, 1, 0, 0, 0, 1, 3, 0, 3, 0, 1); ex[0] = 10'b00111_010_1_0;
        st[1] = mk_s(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 1); ex[1] = 10'b11111_000_1_0;
        st[2] = mk_s(0, 1, 0, 0, 0, 1, 3, 3, 5, 0, 1); ex[2] = 10'b11111_000_1_0;
        st[3] = mk_s(0, 1, 0, 0, 0, 1, 6, 6, 0, 1, 0); ex[3] = 10'b00111_010_1_0;
        st[4] = mk_s(0, 1, 0, 0, 0, 0, 6, 6, 6, 1, 1); ex[4] = 10'b11111_000_1_0;
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            sb_q.push_back(ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            n_fail++;
            $display("FAIL load_use_counters: got stall=%0d flush=%0d want 0/0", stall_count, flush_count);
        end
    endtask

    task automatic test_branch();
        stim_t st[3];
        logic [9:0] ex[3];
        logic [9:0] e;
        do_reset();
        st[0] = mk_s(0, 1, 0, 0, 1, 1, 3, 0, 3, 0, 1); ex[0] = 10'b11111_111_1_0;
        st[1] = mk_s(0, 0, 0, 0, 1, 1, 3, 3, 3, 1, 1); ex[1] = 10'b00000_000_1_0;
        st[2] = mk_s(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = 10'b11111_000_1_0;
        for (int i = 0; i < 3; i++) begin
            drive(st[i]);
            sb_q.push_back(ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
            n_chk++;
            if (flush_count !== 16'd1) begin
                n_fail++;
                $display("FAIL branch_flush_count[%0d]: got %0d want 1", i, flush_count);
            end
        end
        n_chk++;
        if (stall_count !== 16'd1) begin
            n_fail++;
            $display("FAIL branch_stall_count: got %0d want 1", stall_count);
        end
    endtask

    task automatic test_reset_midstall();
        stim_t st[4];
        logic [9:0] ex[4];
        logic [9:0] e;
        do_reset();
        st[0] = mk_s(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); ex[0] = 10'b00000_000_1_1;
        st[1] = mk_s(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[1] = 10'b00000_000_0_0;
        st[2] = mk_s(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[2] = 10'b01111_111_0_0;
        // Captured data response must be gone: still waiting on dmem.
        st[3] = mk_s(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); ex[3] = 10'b00000_000_1_1;
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            sb_q.push_back(ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL reset_midstall[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (stall_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_midstall_stall_count: got %0d want 1", stall_count);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] want;
        do_reset();
        drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (65534) @(posedge clk);
        #1;
        n_chk++;
        if (stall_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_fffe: got %h want fffe", stall_count);
        end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(10'b00000_000_1_0);
            @(negedge clk);
            want = sb_q.pop_front();
            n_chk++;
            if (obs !== want[9:0]) begin
                n_fail++;
                $display("FAIL sat_stall_strobes[%0d]: got %b want %b", i, obs, want[9:0]);
            end
            @(posedge clk); #1;
            n_chk++;
            if (stall_count !== 16'hFFFF) begin
                n_fail++;
                $display("FAIL sat_hold[%0d]: got %h want ffff", i, stall_count);
            end
        end
    endtask

    initial begin
        drive(mk_s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        test_reset();
        test_imem_wait();
        test_dmem_first();
        test_load_use();
        test_branch();
        test_reset_midstall();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
